// File: rtl/selftrig_pkg.sv
// Shared definitions for the self-trigger stage and the downstream trigger FIFO.
package selftrig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABOVE   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int SAMPLE_W = 16;
    localparam int HYST_W   = 15;
    localparam int REL_W    = SAMPLE_W + 1;

    // One extra bit so threshold - hysteresis never wraps.
    function automatic logic signed [REL_W-1:0] release_level(
        input logic signed [SAMPLE_W-1:0] thr,
        input logic        [HYST_W-1:0]   hyst
    );
        return $signed({thr[SAMPLE_W-1], thr}) - $signed({{(REL_W-HYST_W){1'b0}}, hyst});
    endfunction

endpackage

// File: rtl/selftrigger_peak_detector_sat_counter.sv
// Saturating up/down counter with load; sat flags that this enabled step reaches the limit.
module sat_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         en,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (down) begin
                if (cnt_q != '0) cnt_d = cnt_q - ONE;
            end else if (cnt_q != MAX) begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)   cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign sat = en & (down ? (cnt_q == ONE) : (cnt_q == MAX - ONE));

endmodule

// File: rtl/selftrigger_peak_detector.sv
// Self-trigger: threshold crossing with hysteresis, peak tracking, one-cycle
// trigger record at pulse end, then a programmable holdoff.
module selftrigger_peak_detector
    import selftrig_pkg::*;
#(
    parameter int WIDTH_W   = 10,
    parameter int HOLDOFF_W = 12,
    parameter int TS_W      = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic        [TS_W-1:0]     timestamp,
    input  logic signed [SAMPLE_W-1:0] threshold,
    input  logic        [HYST_W-1:0]   hysteresis,
    input  logic        [HOLDOFF_W-1:0] holdoff_len,
    output logic                       trig_valid,
    output logic signed [SAMPLE_W-1:0] trig_peak,
    output logic        [WIDTH_W-1:0]  trig_peak_off,
    output logic        [WIDTH_W-1:0]  trig_width,
    output logic        [TS_W-1:0]     trig_ts,
    output logic                       trig_sat,
    output logic                       busy
);

    localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);
    localparam logic [WIDTH_W-1:0] W_MAX = {WIDTH_W{1'b1}};

    state_e                      state_q, state_d;
    logic signed [SAMPLE_W-1:0]  thr_sh_q, thr_sh_d, peak_q, peak_d;
    logic        [HYST_W-1:0]    hyst_sh_q, hyst_sh_d;
    logic        [HOLDOFF_W-1:0] hold_sh_q, hold_sh_d, hold_cnt;
    logic        [TS_W-1:0]      ts_q, ts_d;

    logic                        trig_valid_q, trig_valid_d, trig_sat_q, trig_sat_d;
    logic                        busy_q, busy_d;
    logic signed [SAMPLE_W-1:0]  trig_peak_q, trig_peak_d;
    logic        [WIDTH_W-1:0]   trig_peak_off_q, trig_peak_off_d, trig_width_q, trig_width_d;
    logic        [TS_W-1:0]      trig_ts_q, trig_ts_d;

    logic [WIDTH_W-1:0] width_cnt, poff_cnt, w_val, p_val;
    logic               w_en, w_load, w_sat, p_load, poff_sat_unused;
    logic               h_en, h_load, h_sat;
    logic               crossing, above_rel, new_peak, emit;
    logic signed [REL_W-1:0] rel_lvl, x_ext;

    assign rel_lvl   = release_level(thr_sh_q, hyst_sh_q);
    assign x_ext     = {x[SAMPLE_W-1], x};
    assign crossing  = x > threshold;
    assign above_rel = x_ext > rel_lvl;
    assign new_peak  = x > peak_q;

    sat_counter #(.W(WIDTH_W)) u_width (
        .clk, .reset_n, .clear, .en(w_en), .down(1'b0), .load(w_load),
        .load_val(w_val), .cnt(width_cnt), .sat(w_sat)
    );
    sat_counter #(.W(WIDTH_W)) u_peak_off (
        .clk, .reset_n, .clear, .en(1'b0), .down(1'b0), .load(p_load),
        .load_val(p_val), .cnt(poff_cnt), .sat(poff_sat_unused)
    );
    sat_counter #(.W(HOLDOFF_W)) u_holdoff (
        .clk, .reset_n, .clear, .en(h_en), .down(1'b1), .load(h_load),
        .load_val(hold_sh_q), .cnt(hold_cnt), .sat(h_sat)
    );

    // Counter controls depend only on registered state and inputs, never on counter flags.
    always_comb begin
        w_en   = 1'b0;
        w_load = 1'b0;
        w_val  = W_ONE;
        p_load = 1'b0;
        p_val  = '0;
        h_en   = 1'b0;
        if (enable) begin
            unique case (state_q)
                IDLE: if (crossing) begin
                    w_load = 1'b1;
                    p_load = 1'b1;
                end
                ABOVE: if (above_rel) begin
                    w_en = 1'b1;
                    if (new_peak) begin
                        p_load = 1'b1;
                        p_val  = width_cnt;
                    end
                end
                HOLDOFF: h_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        thr_sh_d        = thr_sh_q;
        hyst_sh_d       = hyst_sh_q;
        hold_sh_d       = hold_sh_q;
        peak_d          = peak_q;
        ts_d            = ts_q;
        emit            = 1'b0;
        h_load          = 1'b0;
        trig_sat_d      = trig_sat_q;
        trig_peak_d     = trig_peak_q;
        trig_peak_off_d = trig_peak_off_q;
        trig_width_d    = trig_width_q;
        trig_ts_d       = trig_ts_q;

        if (state_q == IDLE) begin
            thr_sh_d  = threshold;
            hyst_sh_d = hysteresis;
            hold_sh_d = holdoff_len;
        end

        if (enable) begin
            unique case (state_q)
                IDLE: if (crossing) begin
                    state_d = ABOVE;
                    peak_d  = x;
                    ts_d    = timestamp;
                end
                ABOVE: begin
                    if (above_rel) begin
                        if (new_peak) peak_d = x;
                        emit = w_sat;
                    end else begin
                        emit = 1'b1;
                    end
                    if (emit) begin
                        h_load  = 1'b1;
                        state_d = (hold_sh_q == '0) ? IDLE : HOLDOFF;
                    end
                end
                HOLDOFF: if (h_sat || hold_cnt == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Record is taken from the post-sample values so a saturating sample counts.
        if (emit) begin
            trig_sat_d      = above_rel;
            trig_peak_d     = peak_d;
            trig_peak_off_d = p_load ? p_val : poff_cnt;
            trig_width_d    = above_rel ? W_MAX : width_cnt;
            trig_ts_d       = ts_q;
        end
        trig_valid_d = emit;
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            thr_sh_q        <= '0;
            hyst_sh_q       <= '0;
            hold_sh_q       <= '0;
            peak_q          <= '0;
            ts_q            <= '0;
            trig_valid_q    <= 1'b0;
            trig_sat_q      <= 1'b0;
            trig_peak_q     <= '0;
            trig_peak_off_q <= '0;
            trig_width_q    <= '0;
            trig_ts_q       <= '0;
            busy_q          <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            peak_q       <= '0;
            ts_q         <= '0;
            trig_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            thr_sh_q        <= thr_sh_d;
            hyst_sh_q       <= hyst_sh_d;
            hold_sh_q       <= hold_sh_d;
            peak_q          <= peak_d;
            ts_q            <= ts_d;
            trig_valid_q    <= trig_valid_d;
            trig_sat_q      <= trig_sat_d;
            trig_peak_q     <= trig_peak_d;
            trig_peak_off_q <= trig_peak_off_d;
            trig_width_q    <= trig_width_d;
            trig_ts_q       <= trig_ts_d;
            busy_q          <= busy_d;
        end
    end

    assign trig_valid    = trig_valid_q;
    assign trig_peak     = trig_peak_q;
    assign trig_peak_off = trig_peak_off_q;
    assign trig_width    = trig_width_q;
    assign trig_ts       = trig_ts_q;
    assign trig_sat      = trig_sat_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_selftrigger_peak_detector.sv
// Directed bench for the self-trigger peak detector (WIDTH_W=4 to reach saturation quickly).
module tb_selftrigger_peak_detector;

    localparam int WIDTH_W   = 4;
    localparam int HOLDOFF_W = 12;
    localparam int TS_W      = 64;
    localparam logic [63:0] TSB = 64'h0123_4567_0000_0000;

    logic                 clk = 1'b0;
    logic                 reset_n, clear, enable;
    logic signed [15:0]   x, threshold;
    logic [14:0]          hysteresis;
    logic [HOLDOFF_W-1:0] holdoff_len;
    logic [TS_W-1:0]      timestamp;
    logic                 trig_valid, trig_sat, busy;
    logic signed [15:0]   trig_peak;
    logic [WIDTH_W-1:0]   trig_peak_off, trig_width;
    logic [TS_W-1:0]      trig_ts;

    selftrigger_peak_detector #(.WIDTH_W(WIDTH_W), .HOLDOFF_W(HOLDOFF_W), .TS_W(TS_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .x(x),
        .timestamp(timestamp), .threshold(threshold), .hysteresis(hysteresis),
        .holdoff_len(holdoff_len), .trig_valid(trig_valid), .trig_peak(trig_peak),
        .trig_peak_off(trig_peak_off), .trig_width(trig_width), .trig_ts(trig_ts),
        .trig_sat(trig_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int sidx, ntrig, trig_at;
    logic [63:0] cap_peak, cap_off, cap_width, cap_ts, cap_sat;
    logic signed [15:0] xq[$];
    logic eq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One sample per clk; outputs are looked at 1 time unit after the capturing edge.
    task automatic step(input logic signed [15:0] xv, input logic en);
        x         = xv;
        enable    = en;
        timestamp = TSB + 64'(sidx);
        @(posedge clk);
        #1;
        if (trig_valid) begin
            ntrig++;
            trig_at   = sidx;
            cap_peak  = 64'(trig_peak);
            cap_off   = 64'(trig_peak_off);
            cap_width = 64'(trig_width);
            cap_ts    = trig_ts;
            cap_sat   = 64'(trig_sat);
        end
        sidx++;
    endtask

    task automatic begin_seq();
        sidx = 0; ntrig = 0; trig_at = -1;
    endtask

    task automatic play();
        foreach (xq[i]) step(xq[i], 1'b1);
    endtask

    task automatic play_gap();
        foreach (xq[i]) step(xq[i], eq[i]);
    endtask

    task automatic flush();
        repeat (10) step(16'sd0, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(trig_valid), 64'd0);
        chk({tag, "_peak"},  64'(trig_peak), 64'd0);
        chk({tag, "_off"},   64'(trig_peak_off), 64'd0);
        chk({tag, "_width"}, 64'(trig_width), 64'd0);
        chk({tag, "_ts"},    trig_ts, 64'd0);
        chk({tag, "_sat"},   64'(trig_sat), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; enable = 1'b0; x = '0; timestamp = '0;
        threshold = 16'sd100; hysteresis = 15'd20; holdoff_len = 12'd4;
        begin_seq();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // single pulse
        begin_seq();
        step(16'sd0, 1'b1);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        step(16'sd150, 1'b1);
        chk("t1_busy_rise", 64'(busy), 64'd1);
        xq = '{16'sd300, 16'sd250, 16'sd90, 16'sd79, 16'sd0};
        play();
        chk("t1_ntrig", 64'(ntrig), 64'd1);
        chk("t1_at",    64'(trig_at), 64'd5);
        chk("t1_peak",  cap_peak, 64'd300);
        chk("t1_off",   cap_off, 64'd1);
        chk("t1_width", cap_width, 64'd4);
        chk("t1_ts",    cap_ts, TSB + 64'd1);
        chk("t1_sat",   cap_sat, 64'd0);
        chk("t1_busy_hold", 64'(busy), 64'd1);
        flush();

        // hysteresis chatter
        begin_seq();
        xq = '{16'sd150, 16'sd85, 16'sd150, 16'sd79};
        play();
        chk("t2_ntrig", 64'(ntrig), 64'd1);
        chk("t2_at",    64'(trig_at), 64'd3);
        chk("t2_width", cap_width, 64'd3);
        chk("t2_peak",  cap_peak, 64'd150);
        chk("t2_off",   cap_off, 64'd0);
        flush();

        // holdoff 4: crossings at +2 and +4 ignored, +5 triggers
        begin_seq();
        xq = '{16'sd150, 16'sd79, 16'sd0, 16'sd150, 16'sd79, 16'sd150, 16'sd200, 16'sd50};
        play();
        chk("t3_ntrig", 64'(ntrig), 64'd2);
        chk("t3_at",    64'(trig_at), 64'd7);
        chk("t3_peak",  cap_peak, 64'd200);
        chk("t3_width", cap_width, 64'd1);
        chk("t3_ts",    cap_ts, TSB + 64'd6);
        flush();

        // holdoff 0: crossing right after release triggers
        holdoff_len = 12'd0;
        begin_seq();
        xq = '{16'sd150, 16'sd79, 16'sd150, 16'sd79};
        play();
        chk("t3z_ntrig", 64'(ntrig), 64'd2);
        chk("t3z_at",    64'(trig_at), 64'd3);
        chk("t3z_ts",    cap_ts, TSB + 64'd2);
        chk("t3z_busy",  64'(busy), 64'd0);
        flush();
        holdoff_len = 12'd4;

        // enable gaps: same record as the gap-free single pulse
        begin_seq();
        xq = '{16'sd0, 16'sd150, 16'sd500, 16'sd300, 16'sd20, 16'sd250, 16'sd90, 16'sd500, 16'sd79};
        eq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        play_gap();
        chk("t4_ntrig", 64'(ntrig), 64'd1);
        chk("t4_at",    64'(trig_at), 64'd8);
        chk("t4_peak",  cap_peak, 64'd300);
        chk("t4_off",   cap_off, 64'd1);
        chk("t4_width", cap_width, 64'd4);
        chk("t4_ts",    cap_ts, TSB + 64'd1);
        ntrig = 0;
        xq = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd150, 16'sd200, 16'sd200, 16'sd50};
        eq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        play_gap();
        chk("t4h_ntrig", 64'(ntrig), 64'd1);
        chk("t4h_at",    64'(trig_at), 64'd17);
        chk("t4h_ts",    cap_ts, TSB + 64'd16);
        flush();

        // saturation at width 15, new peak on the saturating sample
        begin_seq();
        xq.delete();
        for (int i = 0; i < 20; i++) xq.push_back((i == 14) ? 16'sd210 : 16'sd200);
        play();
        chk("t5_ntrig", 64'(ntrig), 64'd1);
        chk("t5_at",    64'(trig_at), 64'd14);
        chk("t5_width", cap_width, 64'd15);
        chk("t5_sat",   cap_sat, 64'd1);
        chk("t5_peak",  cap_peak, 64'd210);
        chk("t5_off",   cap_off, 64'd14);
        chk("t5_busy",  64'(busy), 64'd1);
        flush();
        chk("t5_retrig_n",   64'(ntrig), 64'd2);
        chk("t5_retrig_ts",  cap_ts, TSB + 64'd19);
        chk("t5_retrig_sat", cap_sat, 64'd0);

        // clear mid-pulse drops the pulse, record fields hold
        begin_seq();
        xq = '{16'sd150, 16'sd200};
        play();
        clear = 1'b1;
        step(16'sd0, 1'b1);
        chk("t6_busy",  64'(busy), 64'd0);
        chk("t6_valid", 64'(trig_valid), 64'd0);
        clear = 1'b0;
        xq = '{16'sd79, 16'sd0};
        play();
        chk("t6_ntrig",   64'(ntrig), 64'd0);
        chk("t6_hold_pk", 64'(trig_peak), 64'd200);

        // threshold change mid-pulse: release still at old 80
        begin_seq();
        step(16'sd150, 1'b1);
        threshold = 16'sd1000; hysteresis = 15'd0;
        xq = '{16'sd120, 16'sd85, 16'sd79};
        play();
        chk("t7_ntrig", 64'(ntrig), 64'd1);
        chk("t7_at",    64'(trig_at), 64'd3);
        chk("t7_width", cap_width, 64'd3);
        threshold = 16'sd100; hysteresis = 15'd20;
        flush();

        // reset mid-pulse
        begin_seq();
        step(16'sd150, 1'b1);
        chk("t8_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        step(16'sd0, 1'b1);
        chk_all_zero("t8_reset");
        reset_n = 1'b1;
        step(16'sd79, 1'b1);
        chk("t8_ntrig", 64'(ntrig), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/selftrigger_peak_detector.md
# selftrigger_peak_detector

- Self-trigger stage directly downstream of the pedestal-recovery IIR integrator; consumes its filtered 16-bit signed output.
- Detects threshold crossings with hysteresis and tracks the pulse maximum.
- At pulse end, emits a one-cycle trigger record: peak amplitude, peak offset, width and crossing timestamp.
- Enforces a programmable holdoff between triggers.

## Interface
Parameters:
- WIDTH_W, 10, width of pulse-width and peak-offset counters (saturating)
- HOLDOFF_W, 12, width of holdoff length/counter
- TS_W, 64, timestamp width

Ports:
- clk  in  1  system clock, same domain as the integrator
- reset_n  in  1  synchronous, active-low reset
- clear  in  1  synchronous soft clear: state to IDLE, counters zero, configuration kept
- enable  in  1  sample qualifier; same enable that drives the integrator
- x  in  16  signed filtered sample (integrator y)
- timestamp  in  TS_W  free-running timestamp, aligned with x
- threshold  in  16  signed trigger level
- hysteresis  in  15  unsigned; release level = threshold − hysteresis
- holdoff_len  in  HOLDOFF_W  enabled samples to ignore after a trigger
- trig_valid  out  1  one-cycle trigger strobe
- trig_peak  out  16  signed maximum sample of the pulse
- trig_peak_off  out  WIDTH_W  samples from crossing to first occurrence of the maximum
- trig_width  out  WIDTH_W  enabled samples above release level, including the crossing sample
- trig_ts  out  TS_W  timestamp of the crossing sample
- trig_sat  out  1  width counter saturated before release
- busy  out  1  high in ABOVE or HOLDOFF

## Operation
- **FSM states:** IDLE, ABOVE, HOLDOFF. Only cycles with enable=1 are samples. With enable=0, state, counters and captured values freeze and trig_valid stays 0.
- **Configuration latching:** threshold, hysteresis and holdoff_len are latched into shadow registers only while in IDLE. Changes mid-pulse or mid-holdoff take effect at the next IDLE.
- **Release level:** computed as 17-bit signed threshold − hysteresis; no wrap. Comparisons are signed 17-bit.
- **IDLE:**
  - On a sample with x > threshold: go to ABOVE.
  - Capture peak=x, peak_off=0, width=1, ts=timestamp.
- **ABOVE, sample with x > release:**
  - width increments, saturating at 2^WIDTH_W−1.
  - If x > peak: peak=x and peak_off=width (value before increment). Ties keep the earlier offset.
- **ABOVE, sample with x ≤ release:**
  - Emit a trigger; this sample is not counted in width.
  - Load the holdoff counter with holdoff_len and go to HOLDOFF, or go straight to IDLE if holdoff_len=0.
- **ABOVE, saturation:** when width reaches the maximum, set trig_sat and force an emit on that same sample.
- **HOLDOFF:**
  - The counter decrements on each sample; at 1 → 0 the FSM enters IDLE.
  - Crossings during holdoff are ignored.
  - The first crossing evaluation happens on the sample after IDLE is entered.
- **Clear / reset:**
  - clear or reset_n=0 → IDLE with all counters 0. Any pulse in progress is dropped without a trigger.
  - Reset also zeroes the shadow configuration.
  - reset_n has priority over clear, and clear has priority over enable.

## Timing
- **Reset values:** all outputs 0 (trig_valid, trig_peak, trig_peak_off, trig_width, trig_ts, trig_sat, busy).
- **Output registers:**
  - All outputs are registered.
  - trig_* fields update together with trig_valid and hold their value until the next trigger.
- **Trigger latency:** trig_valid goes high one clk after the edge that samples the releasing (or saturating) enabled sample, and lasts exactly one clk.
- **Back-to-back:** no back-pressure. Consecutive triggers are separated by at least holdoff_len+1 enabled samples, and at least 2 samples with holdoff 0.
- **busy:** rises one clk after the crossing edge and falls one clk after IDLE is re-entered.
- **Upstream alignment:** the integrator output lags its input by one clk. This block adds no alignment of its own; timestamp must be aligned with x by the integrator wrapper.

## Structure
- Shared package `selftrig_pkg`: state encoding (IDLE=0, ABOVE=1, HOLDOFF=2) and the trigger-record field widths, shared with the downstream trigger FIFO.
- Sub-module `sat_counter` (parameterised width, enable, load, saturation flag), used for width, peak offset and holdoff.
- Everything else stays flat in one module.

## Test plan
- **Single pulse:** threshold=100, hyst=20, holdoff=4; samples 0,150,300,250,90,79,0 → one trigger with peak=300, peak_off=1, width=4, trig_ts=ts of the 150 sample; trig_valid 1 clk after the 79 sample.
- **Hysteresis chatter:** samples 150,85,150,79 (threshold 100, hyst 20) → exactly one trigger, width=3.
- **Holdoff:** holdoff=4, second pulse starting 2 samples after release → ignored; a pulse starting 5 samples after release → triggers. With holdoff=0, a crossing on the sample right after release → triggers.
- **Enable gaps:** enable toggling 1/0 during a pulse → width, peak_off and holdoff count only enabled samples; trig fields match the gap-free run.
- **Saturation:** WIDTH_W=4, 20 samples above threshold → trigger on the 15th sample with width=15 and trig_sat=1; then HOLDOFF.
- **Reset/clear mid-pulse:** clear asserted in ABOVE → no trigger, busy=0 next clk; reset_n=0 → all outputs 0; threshold changed mid-pulse → release uses the old shadow value.
